param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
// - Parametrised, registered successor to the 16-bit load/increment counter datapath.
// - Single-clock WIDTH-bit counter: synchronous set-all-ones, clear, parallel load,
//   up/down count with programmable step, and wrap or saturate mode.
// - Registered status (wrap pulse, zero, all-ones) for timer and event-count slices.
// PARAMETERS
// - WIDTH      16  counter width in bits (>=2)
// - STEP_W     4   width of step_i; count changes by step_i each enabled cycle
// - RST_VAL    0   value of count_o after reset (WIDTH bits, zero-extended)
// - SATURATE   0   0: wrap modulo 2**WIDTH; 1: clamp at all-ones (up) / zero (down)
// PORTS
// - clk        in   1        single clock, all state on rising edge
// - rst_n      in   1        synchronous reset, active-low
// - set_i      in   1        force count to all-ones
// - clr_i      in   1        force count to zero
// - load_i     in   1        load count from load_val_i
// - load_val_i in   WIDTH    parallel load value
// - en_i       in   1        count enable
// - up_i       in   1        1 = count up, 0 = count down
// - step_i     in   STEP_W   step magnitude; 0 = hold
// - count_o    out  WIDTH    registered count
// - wrap_o     out  1        1-cycle pulse: last update wrapped (or hit clamp if SATURATE)
// - zero_o     out  1        count_o == 0 (decoded from register, no extra latency)
// - ones_o     out  1        count_o == all-ones
// BEHAVIOUR
// - Reset (rst_n=0 at edge): count_o=RST_VAL, wrap_o=0; reset overrides all controls.
// - Priority per edge: set_i > clr_i > load_i > en_i. Lower controls ignored that cycle.
// - set/clr/load: count_o takes value next edge (latency 1); wrap_o=0.
// - en_i=1: sum = count_o +/- zero-extended step_i, computed in WIDTH+1 bits.
//   - Wrap mode: count_o <= sum[WIDTH-1:0]; wrap_o=1 iff carry (up) / borrow (down).
//   - Saturate mode: on carry/borrow count_o <= all-ones (up) / 0 (down), wrap_o=1;
//     already at limit and moving further: holds, wrap_o=1 each such cycle.
// - en_i=0 or step_i=0: count_o holds, wrap_o=0.
// - wrap_o registered alongside count_o; deasserts the cycle after unless re-triggered.
// - zero_o/ones_o purely combinational from count_o; never glitch-relevant to timing.
// - step_i wider than range impossible (STEP_W <= WIDTH required; elaboration check).
// CONFIGURATION
// - Macro COUNT_MATCH_EN compiled in: adds ports match_val_i (in, WIDTH) and
//   match_o (out, 1). match_o is registered: high the cycle after an update whose new
//   value equals match_val_i (any source: count/load/set/clr); reset value 0.
//   Also adds param MATCH_RELOAD (default 0): when 1, an enabled count that would land
//   on match_val_i loads load_val_i instead (auto-reload timer) and still pulses match_o.
// - Without COUNT_MATCH_EN: ports and logic absent; behaviour exactly as above.
// TESTING
// - Reset: rst_n=0 one edge with set_i=1 -> count_o=RST_VAL, wrap_o=0, zero_o=1 (RST_VAL=0).
// - Wrap up: load 16'hFFFE, en=1 up=1 step=3 -> count_o=16'h0001, wrap_o=1 one cycle, then 0.
// - Down borrow: load 16'h0002, en=1 up=0 step=5 -> 16'hFFFD wrap_o=1; SATURATE=1 -> 0, wrap_o=1.
// - Priority: set=clr=load=en=1 -> 16'hFFFF, ones_o=1; drop set -> 0; drop clr -> load_val_i.
// - Hold: en=1 step=0 or en=0 for 10 cycles -> count_o unchanged, wrap_o=0 throughout.
// - COUNT_MATCH_EN, MATCH_RELOAD=1: load_val=16'h0003, match_val=16'h0006, step=1 up ->
//   sequence 3,4,5,3,4,5 with match_o pulses on each reload; mid-run rst_n=0 -> RST_VAL.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter. The master drives the controls; the slave is the counter.
// COUNT_MATCH_EN adds match_val_i / match_o to the bundle.
interface param_updown_counter_if #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
);
    logic              set_i;
    logic              clr_i;
    logic              load_i;
    logic [WIDTH-1:0]  load_val_i;
    logic              en_i;
    logic              up_i;
    logic [STEP_W-1:0] step_i;
    logic [WIDTH-1:0]  count_o;
    logic              wrap_o;
    logic              zero_o;
    logic              ones_o;
`ifdef COUNT_MATCH_EN
    logic [WIDTH-1:0]  match_val_i;
    logic              match_o;
`endif

    modport master (
        output set_i, clr_i, load_i, load_val_i, en_i, up_i, step_i,
        input  count_o, wrap_o, zero_o, ones_o
`ifdef COUNT_MATCH_EN
        , output match_val_i
        , input  match_o
`endif
    );

    modport slave (
        input  set_i, clr_i, load_i, load_val_i, en_i, up_i, step_i,
        output count_o, wrap_o, zero_o, ones_o
`ifdef COUNT_MATCH_EN
        , input  match_val_i
        , output match_o
`endif
    );
endinterface

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter: set > clr > load > count priority, programmable step, wrap or saturate.
// Optional macro COUNT_MATCH_EN adds a registered match flag and MATCH_RELOAD auto-reload.
module param_updown_counter #(
    parameter int               WIDTH    = 16,
    parameter int               STEP_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               SATURATE = 1'b0
`ifdef COUNT_MATCH_EN
    , parameter bit             MATCH_RELOAD = 1'b0
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    param_updown_counter_if.slave  bus
);

    if (STEP_W > WIDTH || WIDTH < 2 || STEP_W < 1) begin : g_bad_cfg
        $error("param_updown_counter: need WIDTH >= 2 and 1 <= STEP_W <= WIDTH");
    end

    typedef struct packed {
        logic             wrap;
        logic [WIDTH-1:0] value;
    } step_res_t;

    // Add or subtract the zero-extended step in WIDTH+1 bits; the top bit is carry/borrow.
    function automatic step_res_t count_step(input logic [WIDTH-1:0]  cur,
                                             input logic [STEP_W-1:0] step,
                                             input logic              up);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] sum;
        step_res_t      res;
        ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        sum = up ? ({1'b0, cur} + ext) : ({1'b0, cur} - ext);
        res.wrap  = sum[WIDTH];
        res.value = sum[WIDTH-1:0];
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input step_res_t res, input logic up);
        if (SATURATE && res.wrap) begin
            return up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
        return res.value;
    endfunction

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_candidate;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;
    logic             w_update;
    logic             w_counted;
    step_res_t        w_step_res;

    assign w_step_res = count_step(r_count, bus.step_i, bus.up_i);

    always_comb begin
        w_candidate = r_count;
        w_wrap_next = 1'b0;
        w_update    = 1'b0;
        w_counted   = 1'b0;
        if (bus.set_i) begin
            w_candidate = {WIDTH{1'b1}};
            w_update    = 1'b1;
        end else if (bus.clr_i) begin
            w_candidate = {WIDTH{1'b0}};
            w_update    = 1'b1;
        end else if (bus.load_i) begin
            w_candidate = bus.load_val_i;
            w_update    = 1'b1;
        end else if (bus.en_i && (bus.step_i != '0)) begin
            w_candidate = saturate(w_step_res, bus.up_i);
            w_wrap_next = w_step_res.wrap;
            w_update    = 1'b1;
            w_counted   = 1'b1;
        end
    end

`ifdef COUNT_MATCH_EN
    logic r_match;
    logic w_match_hit;

    // Match looks at the value the update would produce, before any auto-reload substitution.
    assign w_match_hit = w_update && (w_candidate == bus.match_val_i);
    assign w_next      = (MATCH_RELOAD && w_counted && w_match_hit) ? bus.load_val_i : w_candidate;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_match_hit;
        end
    end

    assign bus.match_o = r_match;
`else
    logic w_unused;
    assign w_unused = w_update ^ w_counted;
    assign w_next   = w_candidate;
`endif

    // Stage boundary: count and wrap pulse register together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign bus.count_o = r_count;
    assign bus.wrap_o  = r_wrap;
    assign bus.zero_o  = (r_count == '0);
    assign bus.ones_o  = &r_count;

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised bench for param_updown_counter: a wrap-mode and a saturate-mode instance share stimulus
// and are compared each cycle against an arithmetic reference model.
module tb_param_updown_counter;
    localparam int    WIDTH  = 16;
    localparam int    STEP_W = 4;
    localparam longint MAXV  = (64'd1 << WIDTH) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              t_rst_n;
    logic              t_set, t_clr, t_load, t_en, t_up;
    logic [WIDTH-1:0]  t_load_val;
    logic [STEP_W-1:0] t_step;
    logic [WIDTH-1:0]  t_match_val;

    param_updown_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus0 ();
    param_updown_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus1 ();

    assign bus0.set_i = t_set;      assign bus1.set_i = t_set;
    assign bus0.clr_i = t_clr;      assign bus1.clr_i = t_clr;
    assign bus0.load_i = t_load;    assign bus1.load_i = t_load;
    assign bus0.load_val_i = t_load_val; assign bus1.load_val_i = t_load_val;
    assign bus0.en_i = t_en;        assign bus1.en_i = t_en;
    assign bus0.up_i = t_up;        assign bus1.up_i = t_up;
    assign bus0.step_i = t_step;    assign bus1.step_i = t_step;

`ifdef COUNT_MATCH_EN
    assign bus0.match_val_i = t_match_val;
    assign bus1.match_val_i = t_match_val;
    param_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RST_VAL('0), .SATURATE(1'b0),
                           .MATCH_RELOAD(1'b1))
        u_wrap (.clk(clk), .rst_n(t_rst_n), .bus(bus0.slave));
    param_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RST_VAL('0), .SATURATE(1'b1),
                           .MATCH_RELOAD(1'b0))
        u_sat (.clk(clk), .rst_n(t_rst_n), .bus(bus1.slave));
    localparam bit HAS_MATCH = 1'b1;
`else
    param_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RST_VAL('0), .SATURATE(1'b0))
        u_wrap (.clk(clk), .rst_n(t_rst_n), .bus(bus0.slave));
    param_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RST_VAL('0), .SATURATE(1'b1))
        u_sat (.clk(clk), .rst_n(t_rst_n), .bus(bus1.slave));
    localparam bit HAS_MATCH = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 = wrap instance (auto-reload when match is built), 1 = saturate instance.
    longint m_cnt   [2];
    bit     m_wrap  [2];
    bit     m_match [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input int k, input bit sat, input bit reload);
        longint c, nv;
        bit     upd, counted, w;
        c = m_cnt[k]; nv = c; upd = 0; counted = 0; w = 0;
        if (!t_rst_n) begin
            m_cnt[k] = 0; m_wrap[k] = 0; m_match[k] = 0;
            return;
        end
        if (t_set) begin
            nv = MAXV; upd = 1;
        end else if (t_clr) begin
            nv = 0; upd = 1;
        end else if (t_load) begin
            nv = longint'(t_load_val); upd = 1;
        end else if (t_en && t_step != 0) begin
            upd = 1; counted = 1;
            if (t_up) nv = c + longint'(t_step);
            else      nv = c - longint'(t_step);
            if (nv > MAXV) begin
                w = 1; nv = sat ? MAXV : nv - (MAXV + 1);
            end else if (nv < 0) begin
                w = 1; nv = sat ? 0 : nv + (MAXV + 1);
            end
        end
        m_match[k] = HAS_MATCH && upd && (nv == longint'(t_match_val));
        if (HAS_MATCH && reload && counted && nv == longint'(t_match_val))
            nv = longint'(t_load_val);
        m_cnt[k]  = nv;
        m_wrap[k] = w;
    endtask

    task automatic check_all();
        check("w.count", 64'(bus0.count_o), 64'(m_cnt[0]));
        check("w.wrap",  64'(bus0.wrap_o),  64'(m_wrap[0]));
        check("w.zero",  64'(bus0.zero_o),  64'(m_cnt[0] == 0));
        check("w.ones",  64'(bus0.ones_o),  64'(m_cnt[0] == MAXV));
        check("s.count", 64'(bus1.count_o), 64'(m_cnt[1]));
        check("s.wrap",  64'(bus1.wrap_o),  64'(m_wrap[1]));
        check("s.zero",  64'(bus1.zero_o),  64'(m_cnt[1] == 0));
        check("s.ones",  64'(bus1.ones_o),  64'(m_cnt[1] == MAXV));
`ifdef COUNT_MATCH_EN
        check("w.match", 64'(bus0.match_o), 64'(m_match[0]));
        check("s.match", 64'(bus1.match_o), 64'(m_match[1]));
`endif
    endtask

    // One active edge: model follows the inputs present at the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_update(0, 1'b0, 1'b1);
        model_update(1, 1'b1, 1'b0);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        t_rst_n = 1; t_set = 0; t_clr = 0; t_load = 0; t_en = 0; t_up = 1; t_step = '0;
    endtask

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_wrap[0] = 0; m_wrap[1] = 0; m_match[0] = 0; m_match[1] = 0;
        idle_inputs();
        t_load_val = 16'h1234; t_match_val = 16'h1234;

        // Reset wins over set
        t_rst_n = 0; t_set = 1;
        tick();
        check("rst.count", 64'(bus0.count_o), 64'h0);
        check("rst.zero",  64'(bus0.zero_o), 64'h1);
        idle_inputs();

        // Wrap up from FFFE by 3
        t_load = 1; t_load_val = 16'hFFFE; tick();
        t_load = 0; t_en = 1; t_up = 1; t_step = 4'd3; tick();
        check("wrapup.w", 64'(bus0.count_o), 64'h0001);
        check("wrapup.s", 64'(bus1.count_o), 64'hFFFF);
        check("wrapup.pulse", 64'(bus0.wrap_o), 64'h1);
        t_en = 0; tick();
        check("wrapup.drop", 64'(bus0.wrap_o), 64'h0);

        // Saturated at all-ones, still moving up
        t_en = 1; t_step = 4'd1; tick();
        check("satup.hold", 64'(bus1.count_o), 64'hFFFF);
        check("satup.wrap", 64'(bus1.wrap_o), 64'h1);

        // Down borrow from 2 by 5
        t_en = 0; t_load = 1; t_load_val = 16'h0002; tick();
        t_load = 0; t_en = 1; t_up = 0; t_step = 4'd5; tick();
        check("borrow.w", 64'(bus0.count_o), 64'hFFFD);
        check("borrow.s", 64'(bus1.count_o), 64'h0000);
        check("borrow.sw", 64'(bus1.wrap_o), 64'h1);

        // Priority ladder
        t_set = 1; t_clr = 1; t_load = 1; t_en = 1; t_up = 1; t_step = 4'd7;
        t_load_val = 16'h0ABC; tick();
        check("prio.set", 64'(bus0.count_o), 64'hFFFF);
        check("prio.ones", 64'(bus0.ones_o), 64'h1);
        t_set = 0; tick();
        check("prio.clr", 64'(bus0.count_o), 64'h0000);
        t_clr = 0; tick();
        check("prio.load", 64'(bus0.count_o), 64'h0ABC);
        t_load = 0;

        // Hold: step 0 with enable, then enable low
        t_step = '0; t_en = 1;
        for (int i = 0; i < 10; i++) tick();
        check("hold.step0", 64'(bus0.count_o), 64'h0ABC);
        t_en = 0; t_step = 4'd9;
        for (int i = 0; i < 10; i++) tick();
        check("hold.en0", 64'(bus1.count_o), 64'h0ABC);

`ifdef COUNT_MATCH_EN
        // Auto-reload timer 3,4,5,3,4,5 on the wrap instance
        t_match_val = 16'h0006; t_load_val = 16'h0003; t_load = 1; tick();
        t_load = 0; t_en = 1; t_up = 1; t_step = 4'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("reload.seq", 64'(bus0.count_o), 64'(3 + ((i + 1) % 3)));
            check("reload.match", 64'(bus0.match_o), 64'((i % 3) == 2));
        end
        t_rst_n = 0; tick();
        check("reload.rst", 64'(bus0.count_o), 64'h0);
        check("reload.rstm", 64'(bus0.match_o), 64'h0);
        t_rst_n = 1;
`endif

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            t_rst_n = ($urandom_range(0, 63) != 0);
            t_set   = ($urandom_range(0, 15) == 0);
            t_clr   = ($urandom_range(0, 15) == 0);
            t_load  = ($urandom_range(0, 7) == 0);
            t_en    = ($urandom_range(0, 3) != 0);
            t_up    = $urandom_range(0, 1);
            t_step  = STEP_W'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: t_load_val = 16'hFFFE;
                1: t_load_val = 16'h0001;
                2: t_load_val = 16'h0003;
                default: t_load_val = WIDTH'($urandom);
            endcase
            if (i % 500 == 0)
                t_match_val = (i % 1000 == 0) ? 16'h0006 : WIDTH'($urandom_range(0, 40));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
